// File: rtl/axi_csr_regfile.sv
// axi_csr_regfile
// AXI4-Lite slave register file with per-register access modes
// (RW / RO / WO / W1C), byte-strobe writes, hardware status and event
// inputs, and an interrupt that ORs every W1C bit.
//
// Ports
//   clk, arst_n                      clock, asynchronous active-low reset
//   aw*/w*/b*                        AXI4-Lite write address/data/response
//   ar*/r*                           AXI4-Lite read address/data
//   hw_status [NUM_REGS*DATA_W]      read value of RO registers
//   hw_set    [NUM_REGS*DATA_W]      per-bit set pulses for W1C registers
//   reg_out   [NUM_REGS*DATA_W]      storage contents (RO slices read 0)
//   irq                              OR of all W1C register bits
module axi_csr_regfile #(
   parameter int                         DATA_W      = 32,
   parameter int                         ADDR_W      = 6,
   parameter int                         NUM_REGS    = 16,
   parameter int                         TXN_TIMEOUT = 50,
   parameter logic [2*NUM_REGS-1:0]      REG_ACCESS  = 32'hF0A5_0000,
   parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL   = '0
) (
   input  logic                         clk,
   input  logic                         arst_n,
   input  logic [ADDR_W-1:0]            awaddr,
   input  logic                         awvalid,
   output logic                         awready,
   input  logic [DATA_W-1:0]            wdata,
   input  logic [DATA_W/8-1:0]          wstrb,
   input  logic                         wvalid,
   output logic                         wready,
   output logic [1:0]                   bresp,
   output logic                         bvalid,
   input  logic                         bready,
   input  logic [ADDR_W-1:0]            araddr,
   input  logic                         arvalid,
   output logic                         arready,
   output logic [DATA_W-1:0]            rdata,
   output logic [1:0]                   rresp,
   output logic                         rvalid,
   input  logic                         rready,
   input  logic [NUM_REGS*DATA_W-1:0]   hw_status,
   input  logic [NUM_REGS*DATA_W-1:0]   hw_set,
   output logic [NUM_REGS*DATA_W-1:0]   reg_out,
   output logic                         irq
);

   localparam int STRB_W = DATA_W / 8;
   localparam int OFS_W  = $clog2(STRB_W);
   localparam int CNT_W  = $clog2(TXN_TIMEOUT + 1);

   localparam logic [1:0] M_RW  = 2'b00;
   localparam logic [1:0] M_RO  = 2'b01;
   localparam logic [1:0] M_WO  = 2'b10;
   localparam logic [1:0] M_W1C = 2'b11;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {W_IDLE, W_WAIT_W, W_WAIT_AW, W_RESP} wstate_e;
   typedef enum logic       {R_IDLE, R_RESP} rstate_e;

   wstate_e             wstate_q, wstate_d;
   rstate_e             rstate_q, rstate_d;
   logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [STRB_W-1:0]   wstrb_q, wstrb_d;
   logic [1:0]          bresp_q, bresp_d;
   logic [CNT_W-1:0]    tcnt_q, tcnt_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic [1:0]          rresp_q, rresp_d;
   logic [DATA_W-1:0]   regs_q [NUM_REGS];
   logic [DATA_W-1:0]   regs_d [NUM_REGS];

   // Write currently being committed (address/data may come from latches)
   logic                do_wr;
   logic [ADDR_W-1:0]   wr_addr;
   logic [DATA_W-1:0]   wr_data;
   logic [STRB_W-1:0]   wr_strb;
   logic [ADDR_W-1:0]   wr_idx;
   logic [ADDR_W-1:0]   rd_idx;
   logic [1:0]          wr_resp;

   assign wr_idx = wr_addr >> OFS_W;
   assign rd_idx = araddr >> OFS_W;

   assign bvalid = (wstate_q == W_RESP);
   assign bresp  = bresp_q;
   assign rvalid = (rstate_q == R_RESP);
   assign rdata  = rdata_q;
   assign rresp  = rresp_q;

   // Unmatched indices fall through to DECERR
   always_comb begin
      wr_resp = RESP_DECERR;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (wr_idx == ADDR_W'(i)) begin
            wr_resp = (REG_ACCESS[2*i +: 2] == M_RO) ? RESP_SLVERR : RESP_OKAY;
         end
      end
   end

   // Write FSM
   always_comb begin
      wstate_d = wstate_q;
      awaddr_d = awaddr_q;
      wdata_d  = wdata_q;
      wstrb_d  = wstrb_q;
      bresp_d  = bresp_q;
      tcnt_d   = tcnt_q;
      awready  = 1'b0;
      wready   = 1'b0;
      do_wr    = 1'b0;
      wr_addr  = awaddr;
      wr_data  = wdata;
      wr_strb  = wstrb;
      case (wstate_q)
         W_IDLE: begin
            awready = 1'b1;
            wready  = 1'b1;
            if (awvalid && wvalid) begin
               do_wr    = 1'b1;
               wstate_d = W_RESP;
            end else if (awvalid) begin
               awaddr_d = awaddr;
               tcnt_d   = '0;
               wstate_d = W_WAIT_W;
            end else if (wvalid) begin
               wdata_d  = wdata;
               wstrb_d  = wstrb;
               tcnt_d   = '0;
               wstate_d = W_WAIT_AW;
            end
         end
         W_WAIT_W: begin
            wready  = 1'b1;
            wr_addr = awaddr_q;
            if (wvalid) begin
               do_wr    = 1'b1;
               wstate_d = W_RESP;
            end else if (tcnt_q == CNT_W'(TXN_TIMEOUT - 1)) begin
               bresp_d  = RESP_SLVERR;
               wstate_d = W_RESP;
            end else begin
               tcnt_d = tcnt_q + 1'b1;
            end
         end
         W_WAIT_AW: begin
            awready = 1'b1;
            wr_data = wdata_q;
            wr_strb = wstrb_q;
            if (awvalid) begin
               do_wr    = 1'b1;
               wstate_d = W_RESP;
            end else if (tcnt_q == CNT_W'(TXN_TIMEOUT - 1)) begin
               bresp_d  = RESP_SLVERR;
               wstate_d = W_RESP;
            end else begin
               tcnt_d = tcnt_q + 1'b1;
            end
         end
         default: begin
            if (bready) wstate_d = W_IDLE;
         end
      endcase
      if (do_wr) bresp_d = wr_resp;
   end

   // Storage next state; W1C: bit <= (bit & ~sw_clear) | hw_set, so a
   // simultaneous hardware set wins. RO slices are held at zero.
   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         regs_d[i] = regs_q[i];
         if (REG_ACCESS[2*i +: 2] == M_RO) begin
            regs_d[i] = '0;
         end else begin
            if (do_wr && (wr_idx == ADDR_W'(i))) begin
               for (int b = 0; b < STRB_W; b++) begin
                  if (wr_strb[b]) begin
                     if (REG_ACCESS[2*i +: 2] == M_W1C)
                        regs_d[i][8*b +: 8] = regs_q[i][8*b +: 8] & ~wr_data[8*b +: 8];
                     else
                        regs_d[i][8*b +: 8] = wr_data[8*b +: 8];
                  end
               end
            end
            if (REG_ACCESS[2*i +: 2] == M_W1C)
               regs_d[i] = regs_d[i] | hw_set[i*DATA_W +: DATA_W];
         end
      end
   end

   // Read FSM; reads see pre-write storage because they use regs_q
   always_comb begin
      rstate_d = rstate_q;
      rdata_d  = rdata_q;
      rresp_d  = rresp_q;
      arready  = 1'b0;
      case (rstate_q)
         R_IDLE: begin
            arready = 1'b1;
            if (arvalid) begin
               rstate_d = R_RESP;
               rdata_d  = '0;
               rresp_d  = RESP_DECERR;
               for (int i = 0; i < NUM_REGS; i++) begin
                  if (rd_idx == ADDR_W'(i)) begin
                     case (REG_ACCESS[2*i +: 2])
                        M_RO: begin
                           rdata_d = hw_status[i*DATA_W +: DATA_W];
                           rresp_d = RESP_OKAY;
                        end
                        M_WO: begin
                           rdata_d = '0;
                           rresp_d = RESP_SLVERR;
                        end
                        default: begin
                           rdata_d = regs_q[i];
                           rresp_d = RESP_OKAY;
                        end
                     endcase
                  end
               end
            end
         end
         default: begin
            if (rready) rstate_d = R_IDLE;
         end
      endcase
   end

   always_comb begin
      irq = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (REG_ACCESS[2*i +: 2] == M_W1C) irq = irq | (|regs_q[i]);
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
      assign reg_out[g*DATA_W +: DATA_W] = regs_q[g];
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         wstate_q <= W_IDLE;
         rstate_q <= R_IDLE;
         awaddr_q <= '0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
         bresp_q  <= RESP_OKAY;
         tcnt_q   <= '0;
         rdata_q  <= '0;
         rresp_q  <= RESP_OKAY;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= (REG_ACCESS[2*i +: 2] == M_RO) ? '0 : RESET_VAL[i*DATA_W +: DATA_W];
         end
      end else begin
         wstate_q <= wstate_d;
         rstate_q <= rstate_d;
         awaddr_q <= awaddr_d;
         wdata_q  <= wdata_d;
         wstrb_q  <= wstrb_d;
         bresp_q  <= bresp_d;
         tcnt_q   <= tcnt_d;
         rdata_q  <= rdata_d;
         rresp_q  <= rresp_d;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

endmodule

// File: tb/tb_axi_csr_regfile.sv
// tb_axi_csr_regfile
// Directed bench for axi_csr_regfile (ADDR_W=7 so index 16 is addressable).
module tb_axi_csr_regfile;

   localparam int DW = 32;
   localparam int AW = 7;
   localparam int NR = 16;

   logic              clk;
   logic              arst_n;
   logic [AW-1:0]     awaddr;
   logic              awvalid;
   logic              awready;
   logic [DW-1:0]     wdata;
   logic [3:0]        wstrb;
   logic              wvalid;
   logic              wready;
   logic [1:0]        bresp;
   logic              bvalid;
   logic              bready;
   logic [AW-1:0]     araddr;
   logic              arvalid;
   logic              arready;
   logic [DW-1:0]     rdata;
   logic [1:0]        rresp;
   logic              rvalid;
   logic              rready;
   logic [NR*DW-1:0]  hw_status;
   logic [NR*DW-1:0]  hw_set;
   logic [NR*DW-1:0]  reg_out;
   logic              irq;

   int n_cmp = 0;
   int n_err = 0;

   axi_csr_regfile #(
      .DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .TXN_TIMEOUT(50)
   ) dut (
      .clk(clk), .arst_n(arst_n),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .hw_status(hw_status), .hw_set(hw_set), .reg_out(reg_out), .irq(irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] rg(input int i);
      return reg_out[i*DW +: DW];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait (bounded) for bvalid; lat = cycles waited after the handshake edge
   task automatic wait_b(output logic [1:0] resp, output int lat);
      lat = 0;
      while (!bvalid && lat < 100) begin
         tick();
         lat++;
      end
      if (!bvalid) chk_eq("bvalid_wait_expired", 0, 1);
      resp = bresp;
   endtask

   task automatic axi_wr(input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [3:0] s, output logic [1:0] resp, output int lat);
      awaddr  = a;
      awvalid = 1'b1;
      wdata   = d;
      wstrb   = s;
      wvalid  = 1'b1;
      tick();
      awvalid = 1'b0;
      wvalid  = 1'b0;
      wait_b(resp, lat);
      tick();
   endtask

   task automatic axi_rd(input logic [AW-1:0] a, output logic [DW-1:0] d,
                         output logic [1:0] resp, output int lat);
      araddr  = a;
      arvalid = 1'b1;
      tick();
      arvalid = 1'b0;
      lat = 0;
      while (!rvalid && lat < 100) begin
         tick();
         lat++;
      end
      if (!rvalid) chk_eq("rvalid_wait_expired", 0, 1);
      d    = rdata;
      resp = rresp;
      tick();
   endtask

   initial begin
      logic [1:0]    resp;
      logic [DW-1:0] d;
      int            lat;
      int            n;

      arst_n = 1'b0;
      awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
      bready = 1'b1; araddr = '0; arvalid = 1'b0; rready = 1'b1;
      hw_status = '0; hw_set = '0;
      tick();
      tick();

      // Reset state
      chk_eq("rst_awready", awready, 1);
      chk_eq("rst_wready", wready, 1);
      chk_eq("rst_arready", arready, 1);
      chk_eq("rst_bvalid", bvalid, 0);
      chk_eq("rst_rvalid", rvalid, 0);
      chk_eq("rst_bresp", bresp, 0);
      chk_eq("rst_rresp", rresp, 0);
      chk_eq("rst_rdata", rdata, 0);
      chk_eq("rst_irq", irq, 0);
      chk_eq("rst_reg0", rg(0), 0);
      arst_n = 1'b1;
      tick();

      // Strobed write to reg 0 then read back
      axi_wr(7'h00, 32'hDEADBEEF, 4'b0101, resp, lat);
      chk_eq("wr0_bresp", resp, 2'b00);
      chk_eq("wr0_latency", lat, 0);
      chk_eq("wr0_reg", rg(0), 32'h00AD00EF);
      axi_rd(7'h00, d, resp, lat);
      chk_eq("rd0_data", d, 32'h00AD00EF);
      chk_eq("rd0_rresp", resp, 2'b00);
      chk_eq("rd0_latency", lat, 0);

      // AW at cycle 0, W at cycle 3 to reg 2
      awaddr = 7'h08; awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      for (int c = 1; c <= 2; c++) begin
         chk_eq("split_awready", awready, 0);
         chk_eq("split_bvalid", bvalid, 0);
         tick();
      end
      wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1;
      tick();
      wvalid = 1'b0;
      chk_eq("split_bvalid_c4", bvalid, 1);
      chk_eq("split_bresp", bresp, 2'b00);
      chk_eq("split_reg2", rg(2), 32'h12345678);
      tick();
      chk_eq("split_done", bvalid, 0);

      // Timeout on reg 1 with AW only
      axi_wr(7'h04, 32'hCAFEF00D, 4'hF, resp, lat);
      chk_eq("pre_to_reg1", rg(1), 32'hCAFEF00D);
      awaddr = 7'h04; awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      chk_eq("to_wait_bvalid", bvalid, 0);
      n = 0;
      while (!bvalid && n < 200) begin
         tick();
         n++;
      end
      chk_eq("to_cycles", n, 50);
      chk_eq("to_bresp", bresp, 2'b10);
      chk_eq("to_reg1_kept", rg(1), 32'hCAFEF00D);
      tick();
      chk_eq("to_idle", bvalid, 0);

      // W-first write after timeout: W to idle, then AW for reg 5
      wdata = 32'hA5A5A5A5; wstrb = 4'hF; wvalid = 1'b1;
      tick();
      wvalid = 1'b0;
      chk_eq("wfirst_wready", wready, 0);
      chk_eq("wfirst_awready", awready, 1);
      awaddr = 7'h14; awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      chk_eq("wfirst_bvalid", bvalid, 1);
      chk_eq("wfirst_reg5", rg(5), 32'hA5A5A5A5);
      tick();

      // RO, WO and out-of-range accesses
      axi_wr(7'h20, 32'hFFFFFFFF, 4'hF, resp, lat);
      chk_eq("ro_wr_bresp", resp, 2'b10);
      chk_eq("ro_wr_reg8", rg(8), 0);
      hw_status[8*DW +: DW] = 32'h5A5A1234;
      axi_rd(7'h20, d, resp, lat);
      chk_eq("ro_rd_data", d, 32'h5A5A1234);
      chk_eq("ro_rd_rresp", resp, 2'b00);
      axi_wr(7'h28, 32'h11112222, 4'hF, resp, lat);
      chk_eq("wo_wr_bresp", resp, 2'b00);
      chk_eq("wo_reg10", rg(10), 32'h11112222);
      axi_rd(7'h28, d, resp, lat);
      chk_eq("wo_rd_data", d, 0);
      chk_eq("wo_rd_rresp", resp, 2'b10);
      axi_rd(7'h40, d, resp, lat);
      chk_eq("oor_rd_data", d, 0);
      chk_eq("oor_rd_rresp", resp, 2'b11);
      axi_wr(7'h40, 32'h1, 4'hF, resp, lat);
      chk_eq("oor_wr_bresp", resp, 2'b11);

      // W1C register 14 and irq
      hw_set[14*DW + 3] = 1'b1;
      tick();
      hw_set[14*DW + 3] = 1'b0;
      chk_eq("w1c_set_reg14", rg(14), 32'h8);
      chk_eq("w1c_set_irq", irq, 1);
      axi_wr(7'h38, 32'h8, 4'hF, resp, lat);
      chk_eq("w1c_clr_bresp", resp, 2'b00);
      chk_eq("w1c_clr_reg14", rg(14), 0);
      chk_eq("w1c_clr_irq", irq, 0);
      hw_set[14*DW + 3] = 1'b1;
      axi_wr(7'h38, 32'h8, 4'hF, resp, lat);
      hw_set[14*DW + 3] = 1'b0;
      chk_eq("w1c_race_reg14", rg(14), 32'h8);
      chk_eq("w1c_race_irq", irq, 1);
      axi_rd(7'h38, d, resp, lat);
      chk_eq("w1c_rd_data", d, 32'h8);

      // bready held low for 5 cycles
      bready = 1'b0;
      awaddr = 7'h0C; awvalid = 1'b1; wdata = 32'h0F0F0F0F; wstrb = 4'hF; wvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      for (int c = 0; c < 5; c++) begin
         chk_eq("bhold_bvalid", bvalid, 1);
         chk_eq("bhold_bresp", bresp, 2'b00);
         chk_eq("bhold_awready", awready, 0);
         tick();
      end
      bready = 1'b1;
      tick();
      chk_eq("bhold_release", bvalid, 0);
      chk_eq("bhold_reg3", rg(3), 32'h0F0F0F0F);

      // Same-cycle read and write of reg 0: read sees old value
      awaddr = 7'h00; awvalid = 1'b1; wdata = 32'h11111111; wstrb = 4'hF; wvalid = 1'b1;
      araddr = 7'h00; arvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      chk_eq("rw_same_rdata", rdata, 32'h00AD00EF);
      chk_eq("rw_same_reg0", rg(0), 32'h11111111);
      tick();

      // Reset in the middle of a W_WAIT_W
      awaddr = 7'h10; awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      tick();
      tick();
      arst_n = 1'b0;
      #1;
      chk_eq("mrst_awready", awready, 1);
      chk_eq("mrst_wready", wready, 1);
      chk_eq("mrst_bvalid", bvalid, 0);
      chk_eq("mrst_reg0", rg(0), 0);
      chk_eq("mrst_irq", irq, 0);
      tick();
      arst_n = 1'b1;
      tick();
      wdata = 32'h77; wstrb = 4'hF; wvalid = 1'b1;
      tick();
      wvalid = 1'b0;
      chk_eq("mrst_no_resume_bvalid", bvalid, 0);
      chk_eq("mrst_reg4", rg(4), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
